ice51_code_dump: RTL and testbench
==================================

// Module: ice51_code_dump
// PURPOSE
//  Readback path for the 1024x8 code memory: on request, reads bytes 0..N from
//  the code RAM port and serialises each as a UART 8N1 frame on a TX line.
//  It is the reverse of the UART loader: it lets the host verify a downloaded
//  image. Sits beside ice51, muxed onto the code memory read port while o_busy.
// PARAMETERS
//  CLKS_PER_BIT  104  clocks per UART bit (12 MHz / 115200); legal >= 2
//  ADDR_W        10   code memory address width
// PORTS
//  i_clk          in   1       clock, all logic on rising edge
//  i_rst          in   1       synchronous reset, active-high
//  i_start        in   1       1-cycle request to begin a dump (ignored while busy)
//  i_last_addr    in   ADDR_W  last address to dump; latched when i_start accepted
//  o_mem_re       out  1       read enable to code memory
//  o_mem_addr     out  ADDR_W  read address to code memory
//  i_mem_data     in   8       read data, valid 1 cycle after o_mem_re
//  o_uart_tx      out  1       serial output, idle high
//  o_busy         out  1       high from start acceptance to end of last stop bit
//  o_done         out  1       1-cycle pulse after last stop bit
// BEHAVIOUR
//  Reset (i_rst=1 at edge): state IDLE, o_uart_tx=1, o_busy=0, o_done=0,
//   o_mem_re=0, o_mem_addr=0, counters cleared. Takes priority over everything,
//   including mid-frame: TX returns high the cycle after reset is sampled.
//  FSM: IDLE -> FETCH -> CAPTURE -> START -> DATA -> STOP -> (FETCH | FINISH) -> IDLE
//   IDLE:    i_start=1 -> latch i_last_addr into last_q, addr_q=0, o_busy=1, -> FETCH.
//   FETCH:   o_mem_re=1, o_mem_addr=addr_q for exactly 1 cycle -> CAPTURE.
//   CAPTURE: shreg <= i_mem_data -> START.
//   START:   tx=0 for CLKS_PER_BIT cycles -> DATA.
//   DATA:    tx=shreg[0], LSB first, shift right each CLKS_PER_BIT; 8 bits -> STOP.
//   STOP:    tx=1 for CLKS_PER_BIT cycles; then if addr_q==last_q -> FINISH,
//            else addr_q<=addr_q+1 -> FETCH.
//   FINISH:  o_done=1, o_busy=0 (this cycle) -> IDLE.
//  Timing: i_start sampled at edge 0 -> FETCH cycle 1, CAPTURE cycle 2, start bit
//   begins cycle 3. Byte period = 10*CLKS_PER_BIT + 2 cycles (2 idle-high gap
//   cycles per FETCH/CAPTURE). Dump of K=last+1 bytes: o_done asserted at cycle
//   1 + K*(10*CLKS_PER_BIT+2).
//  Bit timer: counts 0..CLKS_PER_BIT-1, reloads at bit boundaries; bit counter 0..7.
//  o_uart_tx registered (glitch-free); high in IDLE, FETCH, CAPTURE, FINISH.
//  Address compare uses equality against latched last_q, so last_addr=1023
//   dumps all 1024 bytes with no wrap; addr_q never increments past last_q.
//  last_addr=0 dumps exactly one byte.
//  i_start while busy (incl. FINISH cycle): ignored, no queuing.
//  i_last_addr changes after acceptance: no effect on the running dump.
//  o_mem_re is 0 outside FETCH; o_mem_addr holds addr_q (stable) otherwise.
// TESTING (CLKS_PER_BIT=4, memory model with 1-cycle read latency)
//  Reset then idle 50 cycles -> o_uart_tx=1, o_busy=0, o_done=0, o_mem_re=0.
//  mem[0..2]=A5,00,FF; start, last=2 -> frames decode A5,00,FF; each start bit
//   edge 42 cycles apart; o_done pulse at cycle 127; o_busy low thereafter.
//  Start, last=1; pulse i_start again during byte 0 -> exactly 2 frames, 1 o_done.
//  Start, last=1023 (mem[i]=i[7:0]) -> 1024 frames 00..FF repeating, o_mem_addr
//   peaks at 1023, never returns to 0 before o_done.
//  Assert i_rst during DATA bit 3 -> next cycle tx=1, busy=0; new start gives a
//   clean dump from address 0.
//  Start with last=0, change i_last_addr to 5 next cycle -> single frame only.

Source files
------------

// File: rtl/ice51_code_dump.sv
// Code memory readback: fetches bytes 0..last from the code RAM read port and
// sends each one as a UART 8N1 frame so the host can verify a downloaded image.
module ice51_code_dump #(
    parameter int CLKS_PER_BIT = 104,
    parameter int ADDR_W       = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_last_addr,
    output logic              o_mem_re,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [7:0]        i_mem_data,
    output logic              o_uart_tx,
    output logic              o_busy,
    output logic              o_done
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_START,
        S_DATA,
        S_STOP,
        S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [7:0]          shreg_q, shreg_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [2:0]          bit_q, bit_d;
    logic                tx_q, tx_d;

    logic timer_end;
    logic last_bit;
    logic at_last;

    assign timer_end = (timer_q == TIMER_MAX);
    assign last_bit  = (bit_q == 3'd7);
    assign at_last   = (addr_q == last_q);

    // NOTE: every variable gets its hold value first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        shreg_d = shreg_q;
        timer_d = '0;
        bit_d   = bit_q;

        case (state_q)
            S_IDLE: begin
                bit_d = '0;
                if (i_start) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                    last_d  = i_last_addr;
                end
            end
            S_FETCH:   state_d = S_CAPTURE;
            S_CAPTURE: begin
                shreg_d = i_mem_data;
                state_d = S_START;
            end
            S_START: begin
                timer_d = timer_end ? '0 : timer_q + 1'b1;
                if (timer_end) state_d = S_DATA;
            end
            S_DATA: begin
                timer_d = timer_end ? '0 : timer_q + 1'b1;
                if (timer_end) begin
                    bit_d   = bit_q + 3'd1;
                    shreg_d = shreg_q >> 1;
                    if (last_bit) state_d = S_STOP;
                end
            end
            S_STOP: begin
                timer_d = timer_end ? '0 : timer_q + 1'b1;
                if (timer_end) begin
                    if (at_last) begin
                        state_d = S_FINISH;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Line level is computed from the next state so the registered TX
        // changes exactly at the bit boundary.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            last_q  <= '0;
            shreg_q <= '0;
            timer_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            shreg_q <= shreg_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

    assign o_mem_re   = (state_q == S_FETCH);
    assign o_mem_addr = addr_q;
    assign o_uart_tx  = tx_q;
    assign o_busy     = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign o_done     = (state_q == S_FINISH);

endmodule

// File: tb/tb_ice51_code_dump.sv
// Directed bench for ice51_code_dump: 1-cycle-latency memory model and a
// mid-bit sampling UART receiver; cycle numbers are relative to the start edge.
module tb_ice51_code_dump;

    localparam int CPB = 4;
    localparam int AW  = 10;
    localparam int BYTE_PERIOD = 10 * CPB + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] last_addr;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          uart_tx;
    logic          busy;
    logic          done;

    logic [7:0] mem [1024];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int zero_fetch_cnt = 0;
    int max_addr = 0;

    ice51_code_dump #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_last_addr(last_addr),
        .o_mem_re   (mem_re),
        .o_mem_addr (mem_addr),
        .i_mem_data (mem_data),
        .o_uart_tx  (uart_tx),
        .o_busy     (busy),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_re) mem_data <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (mem_re === 1'b1 && mem_addr == '0) zero_fetch_cnt++;
        if (mem_re === 1'b1 && int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, observed cyc=%0d required <150000", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for a start bit, then samples each bit in its middle.
    task automatic rx_byte(input int budget, output logic [7:0] b, output int start_cyc,
                           output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        b = '0;
        start_cyc = -1;
        @(negedge clk);
        while (uart_tx !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (uart_tx !== 1'b0) return;
        start_cyc = cyc;
        repeat (CPB / 2) @(negedge clk);
        if (uart_tx !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        ok = (uart_tx === 1'b1);
    endtask

    task automatic wait_done(input int budget, output int at_cyc);
        int n;
        n = 0;
        at_cyc = -1;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done === 1'b1) at_cyc = cyc;
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] b0;
        int         sc [3];
        bit         ok;
        bit         ok0;
        int         base;
        int         dc;
        int         zf;
        int         t;
        int         bad;

        rst = 1'b1;
        start = 1'b0;
        last_addr = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
        mem[0] = 8'hA5;
        mem[1] = 8'h00;
        mem[2] = 8'hFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        repeat (50) @(negedge clk);
        check("idle_tx", 32'(uart_tx), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_mem_re", 32'(mem_re), 32'd0);
        check("idle_mem_addr", 32'(mem_addr), 32'd0);

        // Three-byte dump A5,00,FF
        start = 1'b1;
        last_addr = 10'd2;
        @(negedge clk);
        start = 1'b0;
        base = cyc - 1;
        check("t1_fetch_re", 32'(mem_re), 32'd1);
        check("t1_fetch_addr", 32'(mem_addr), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 3; k++) begin
            rx_byte(60, b, sc[k], ok);
            check($sformatf("t1_frame%0d", k), {23'd0, ok, b}, {23'd0, 1'b1, mem[k]});
        end
        check("t1_start0_cyc", 32'(sc[0] - base), 32'd3);
        check("t1_gap01", 32'(sc[1] - sc[0]), 32'(BYTE_PERIOD));
        check("t1_gap12", 32'(sc[2] - sc[1]), 32'(BYTE_PERIOD));
        wait_done(30, t);
        check("t1_done_cyc", 32'(t - base), 32'd127);
        @(negedge clk);
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_done_pulse", 32'(done), 32'd0);

        // Two-byte dump with a second start pulse mid-frame and in FINISH
        dc = done_cnt;
        start = 1'b1;
        last_addr = 10'd1;
        @(negedge clk);
        start = 1'b0;
        fork
            rx_byte(60, b0, sc[0], ok0);
            begin
                repeat (12) @(negedge clk);
                start = 1'b1;
                last_addr = 10'd5;
                @(negedge clk);
                start = 1'b0;
            end
        join
        check("t2_frame0", {23'd0, ok0, b0}, {23'd0, 1'b1, 8'hA5});
        rx_byte(60, b, sc[1], ok);
        check("t2_frame1", {23'd0, ok, b}, {23'd0, 1'b1, 8'h00});
        wait_done(30, t);
        check("t2_done_seen", 32'(t >= 0), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("t2_quiet", 32'(bad), 32'd0);
        check("t2_done_count", 32'(done_cnt - dc), 32'd1);

        // Reset during data bit 3 (A5 bit 3 = 0)
        start = 1'b1;
        last_addr = 10'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("t3_bit3_low", 32'(uart_tx), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("t3_rst_tx", 32'(uart_tx), 32'd1);
        check("t3_rst_busy", 32'(busy), 32'd0);
        check("t3_rst_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte with i_last_addr changed after acceptance
        dc = done_cnt;
        start = 1'b1;
        last_addr = 10'd0;
        @(negedge clk);
        start = 1'b0;
        last_addr = 10'd5;
        base = cyc - 1;
        check("t5_fetch_re", 32'(mem_re), 32'd1);
        check("t5_fetch_addr", 32'(mem_addr), 32'd0);
        rx_byte(60, b, sc[0], ok);
        check("t5_frame", {23'd0, ok, b}, {23'd0, 1'b1, 8'hA5});
        check("t5_start_cyc", 32'(sc[0] - base), 32'd3);
        wait_done(30, t);
        check("t5_done_cyc", 32'(t - base), 32'(1 + BYTE_PERIOD));
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("t5_quiet", 32'(bad), 32'd0);
        check("t5_done_count", 32'(done_cnt - dc), 32'd1);

        // Full 1024-byte dump
        mem[0] = 8'h00;
        mem[1] = 8'h01;
        mem[2] = 8'h02;
        dc = done_cnt;
        zf = zero_fetch_cnt;
        start = 1'b1;
        last_addr = 10'd1023;
        @(negedge clk);
        start = 1'b0;
        base = cyc - 1;
        bad = 0;
        for (int k = 0; k < 1024; k++) begin
            rx_byte(60, b, sc[0], ok);
            if (!ok || b !== 8'(k)) bad++;
            if (!ok) break;
        end
        check("t4_bad_frames", 32'(bad), 32'd0);
        wait_done(60, t);
        check("t4_done_cyc", 32'(t - base), 32'(1 + 1024 * BYTE_PERIOD));
        repeat (5) @(negedge clk);
        check("t4_max_addr", 32'(max_addr), 32'd1023);
        check("t4_zero_fetches", 32'(zero_fetch_cnt - zf), 32'd1);
        check("t4_done_count", 32'(done_cnt - dc), 32'd1);
        check("t4_busy_after", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
